// File: rtl/l2_tlb_ram_ctrl.sv
// L2 TLB SRAM initiator: request issue, 2-deep read response queue,
// and zero-fill sweep after reset or flush.
module l2_tlb_ram_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 44
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  req_ready,
  input  logic                  req_valid,
  input  logic                  req_bits_write,
  input  logic [ADDR_WIDTH-1:0] req_bits_addr,
  input  logic [DATA_WIDTH-1:0] req_bits_data,
  input  logic                  resp_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_bits_data,
  input  logic                  flush_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] RW0_addr,
  output logic                  RW0_en,
  output logic                  RW0_clk,
  output logic                  RW0_wmode,
  output logic [DATA_WIDTH-1:0] RW0_wdata,
  input  logic [DATA_WIDTH-1:0] RW0_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic                  rptr_q, wptr_q;
  logic [DATA_WIDTH-1:0] mem_q [2];

  logic       enq, deq, fire;
  logic [2:0] credit;

  assign RW0_clk        = clock;
  assign resp_valid     = !reset && (occ_q != 2'd0);
  assign resp_bits_data = mem_q[rptr_q];
  assign deq            = resp_valid && resp_ready;
  assign enq            = !reset && inflight_q;
  assign busy           = reset || (state_q == CLEAR);

  // Slots promised: queued + the read in flight, less the one leaving now.
  assign credit = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, deq};

  assign req_ready = !reset && (state_q == RUN) && !flush_valid &&
                     (credit < 3'd2);
  assign fire      = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inflight_d = fire && !req_bits_write;
    occ_d      = occ_q + {1'b0, enq} - {1'b0, deq};
    RW0_en     = 1'b0;
    RW0_wmode  = 1'b0;
    RW0_addr   = '0;
    RW0_wdata  = '0;
    if (!reset) begin
      unique case (state_q)
        CLEAR: begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_addr  = cnt_q[ADDR_WIDTH-1:0];
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        RUN: begin
          if (fire) begin
            RW0_en    = 1'b1;
            RW0_wmode = req_bits_write;
            RW0_addr  = req_bits_addr;
            RW0_wdata = req_bits_data;
          end
          if (flush_valid) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      rptr_q     <= 1'b0;
      wptr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      if (enq) wptr_q <= ~wptr_q;
      if (deq) rptr_q <= ~rptr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem_q[wptr_q] <= RW0_rdata;
  end

endmodule
